// File: rtl/mix_sequencer_if.sv
// ----------------------------------------------------------------------------
// mix_sequencer_if
// Purpose : groups the note-mux, divider handshake and mixed-output signals
//           of the mix sequencer into one bundle.
// Signals :
//   en, sample_tick   - sample-rate trigger and enable        (env -> seq)
//   note_sel          - voice index presented to the note mux (seq -> env)
//   note_sample       - sample of the selected voice          (env -> seq)
//   div_start         - one-cycle divider launch              (seq -> env)
//   div_dividend      - sum of scanned samples                (seq -> env)
//   div_divisor       - active-voice count                    (seq -> env)
//   div_done          - divider result strobe                 (env -> seq)
//   div_quotient      - divider result                        (env -> seq)
//   mixed_sample      - registered mixed output               (seq -> env)
//   sample_valid      - pulse when mixed_sample updates       (seq -> env)
//   busy              - sequencer is not idle                 (seq -> env)
//   overrun           - a tick was dropped while busy         (seq -> env)
// Modports: master = sequencer side, slave = environment side.
// ----------------------------------------------------------------------------
interface mix_sequencer_if #(
   parameter int SAMPLE_W = 12,
   parameter int SUM_W    = 16,
   parameter int CNT_W    = 4
);
   logic                en;
   logic                sample_tick;
   logic [CNT_W-1:0]    note_sel;
   logic [SAMPLE_W-1:0] note_sample;
   logic                div_start;
   logic [SUM_W-1:0]    div_dividend;
   logic [CNT_W-1:0]    div_divisor;
   logic                div_done;
   logic [SUM_W-1:0]    div_quotient;
   logic [SAMPLE_W-1:0] mixed_sample;
   logic                sample_valid;
   logic                busy;
   logic                overrun;

   modport master (
      input  en, sample_tick, note_sample, div_done, div_quotient,
      output note_sel, div_start, div_dividend, div_divisor,
             mixed_sample, sample_valid, busy, overrun
   );

   modport slave (
      output en, sample_tick, note_sample, div_done, div_quotient,
      input  note_sel, div_start, div_dividend, div_divisor,
             mixed_sample, sample_valid, busy, overrun
   );
endinterface

// File: rtl/mix_sequencer.sv
// ----------------------------------------------------------------------------
// mix_sequencer
// Purpose : per-sample controller for the note mixer. On each accepted
//           sample tick it scans every voice through the external note mux,
//           sums the samples and counts the nonzero ones, then averages them
//           with the shared sequential divider (or bypasses it for 0/1
//           active voices) and publishes one saturated, registered sample.
// Ports   :
//   i_clk   - system clock
//   i_nRst  - asynchronous active-low reset
//   io_mix  - mix_sequencer_if.master bundle (see interface header)
// ----------------------------------------------------------------------------
module mix_sequencer #(
   parameter int NUM_NOTES = 13,
   parameter int SAMPLE_W  = 12,
   parameter int SUM_W     = 16,
   parameter int CNT_W     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_nRst,
   mix_sequencer_if.master       io_mix
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DIVIDE,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_NOTES - 1);
   localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** SAMPLE_W) - 1);

   state_t              r_state;
   state_t              w_nextState;
   logic [SUM_W-1:0]    r_sum;
   logic [SUM_W-1:0]    r_result;
   logic [SUM_W-1:0]    r_dividend;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_noteSel;
   logic [CNT_W-1:0]    r_divisor;
   logic [SAMPLE_W-1:0] r_mixed;
   logic                r_sampleValid;
   logic                r_overrun;
   logic [SUM_W-1:0]    w_sumNext;
   logic [CNT_W-1:0]    w_countNext;
   logic                w_lastNote;
   logic                w_tickAccept;
   logic                w_divStart;

   // Running totals including the sample presented this cycle, so the
   // decision at the last voice sees the complete sum and count.
   assign w_sumNext    = r_sum + SUM_W'(io_mix.note_sample);
   assign w_countNext  = r_count + CNT_W'(io_mix.note_sample != '0);
   assign w_lastNote   = (r_noteSel == LAST_IDX);
   assign w_tickAccept = io_mix.sample_tick && io_mix.en;

   // State register.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Fewer than two active voices skip the divider since
   // the average is then either zero or the lone sample itself.
   always_comb begin
      w_nextState = r_state;
      w_divStart  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_tickAccept) begin
               w_nextState = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (w_lastNote) begin
               w_nextState = (w_countNext >= CNT_W'(2)) ? ST_DIVIDE : ST_DONE;
            end
         end
         ST_DIVIDE: begin
            w_divStart  = 1'b1;
            w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            if (io_mix.div_done) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Datapath: accumulation during the scan, divider operands latched on the
   // way into DIVIDE so they stay put for the whole division, and the output
   // register that is only written in DONE. A tick seen outside IDLE is
   // dropped and reported one cycle later.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         r_sum         <= '0;
         r_count       <= '0;
         r_noteSel     <= '0;
         r_result      <= '0;
         r_dividend    <= '0;
         r_divisor     <= '0;
         r_mixed       <= '0;
         r_sampleValid <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_sampleValid <= 1'b0;
         r_overrun     <= (r_state != ST_IDLE) && io_mix.sample_tick;
         case (r_state)
            ST_IDLE: begin
               if (w_tickAccept) begin
                  r_sum     <= '0;
                  r_count   <= '0;
                  r_noteSel <= '0;
               end
            end
            ST_SCAN: begin
               r_sum   <= w_sumNext;
               r_count <= w_countNext;
               if (w_lastNote) begin
                  r_noteSel <= '0;
                  r_result  <= (w_countNext == '0) ? '0 : w_sumNext;
                  if (w_countNext >= CNT_W'(2)) begin
                     r_dividend <= w_sumNext;
                     r_divisor  <= w_countNext;
                  end
               end else begin
                  r_noteSel <= r_noteSel + CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (io_mix.div_done) begin
                  r_result <= io_mix.div_quotient;
               end
            end
            ST_DONE: begin
               r_mixed       <= (r_result > SAT_MAX) ? '1 : r_result[SAMPLE_W-1:0];
               r_sampleValid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign io_mix.note_sel     = r_noteSel;
   assign io_mix.div_start    = w_divStart;
   assign io_mix.div_dividend = r_dividend;
   assign io_mix.div_divisor  = r_divisor;
   assign io_mix.mixed_sample = r_mixed;
   assign io_mix.sample_valid = r_sampleValid;
   assign io_mix.busy         = (r_state != ST_IDLE);
   assign io_mix.overrun      = r_overrun;

endmodule

// File: tb/tb_mix_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mix_sequencer
// Purpose : self-checking bench for mix_sequencer. Directed stimulus pushes
//           expected mixed samples, divider launches and overrun pulses into
//           queues; a monitor pops and compares whenever the DUT presents
//           one of those events. A simple divider model answers div_start.
// ----------------------------------------------------------------------------
module tb_mix_sequencer;

   typedef struct {
      logic [11:0] mix;
      int          cyc;
   } expMix_t;

   typedef struct {
      logic [15:0] dividend;
      logic [3:0]  divisor;
      int          cyc;
   } expDiv_t;

   logic        clk;
   logic        nRst;
   int          cyc;
   int          compared;
   int          mismatched;
   int          validCount;
   logic [11:0] notes [13];

   expMix_t     mixQ [$];
   expDiv_t     divQ [$];
   int          ovrQ [$];
   expMix_t     monMix;
   expDiv_t     monDiv;
   int          monOvr;

   int          divLat;
   logic        forceQuot;
   logic [15:0] forceValue;
   logic [15:0] divQuot;

   mix_sequencer_if bus ();

   mix_sequencer dut (
      .i_clk  (clk),
      .i_nRst (nRst),
      .io_mix (bus)
   );

   // Clock and free-running cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // External note mux: combinational, indexed by the DUT's note_sel.
   assign bus.note_sample = (bus.note_sel < 4'd13) ? notes[bus.note_sel] : 12'd0;

   // Record one comparison and report it if it does not hold.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   // Drive a one-cycle sample_tick; assumes the caller is at a negedge.
   task automatic applyStimulus(input logic enVal, output int tickCyc);
      bus.en          = enVal;
      bus.sample_tick = 1'b1;
      tickCyc         = cyc;
      @(negedge clk);
      bus.sample_tick = 1'b0;
      bus.en          = 1'b0;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic clearNotes();
      for (int i = 0; i < 13; i++) notes[i] = 12'd0;
   endtask

   task automatic pushMix(input logic [11:0] mix, input int at);
      expMix_t e;
      e.mix = mix;
      e.cyc = at;
      mixQ.push_back(e);
   endtask

   task automatic pushDiv(input logic [15:0] dividend, input logic [3:0] divisor,
                          input int at);
      expDiv_t e;
      e.dividend = dividend;
      e.divisor  = divisor;
      e.cyc      = at;
      divQ.push_back(e);
   endtask

   // Divider model: answers each div_start after divLat cycles with either
   // the true quotient or a forced value.
   initial begin
      bus.div_done     = 1'b0;
      bus.div_quotient = 16'd0;
      forever begin
         @(negedge clk);
         if (bus.div_start === 1'b1) begin
            if (forceQuot)
               divQuot = forceValue;
            else if (bus.div_divisor == 4'd0)
               divQuot = 16'hFFFF;
            else
               divQuot = bus.div_dividend / {12'd0, bus.div_divisor};
            repeat (divLat) @(negedge clk);
            bus.div_done     = 1'b1;
            bus.div_quotient = divQuot;
            @(negedge clk);
            bus.div_done     = 1'b0;
            bus.div_quotient = 16'd0;
         end
      end
   end

   // Monitor: pops the matching expectation whenever the DUT shows an event.
   always @(negedge clk) begin
      if (bus.sample_valid === 1'b1) begin
         validCount++;
         if (mixQ.size() == 0) begin
            checkOutput("unexpected_sample_valid", 32'd1, 32'd0);
         end else begin
            monMix = mixQ.pop_front();
            checkOutput("mixed_sample", 32'(bus.mixed_sample), 32'(monMix.mix));
            checkOutput("sample_valid_cycle", cyc, monMix.cyc);
         end
      end
      if (bus.div_start === 1'b1) begin
         if (divQ.size() == 0) begin
            checkOutput("unexpected_div_start", 32'd1, 32'd0);
         end else begin
            monDiv = divQ.pop_front();
            checkOutput("div_dividend", 32'(bus.div_dividend), 32'(monDiv.dividend));
            checkOutput("div_divisor", 32'(bus.div_divisor), 32'(monDiv.divisor));
            checkOutput("div_start_cycle", cyc, monDiv.cyc);
         end
      end
      if (bus.overrun === 1'b1) begin
         if (ovrQ.size() == 0) begin
            checkOutput("unexpected_overrun", 32'd1, 32'd0);
         end else begin
            monOvr = ovrQ.pop_front();
            checkOutput("overrun_cycle", cyc, monOvr);
         end
      end
   end

   // Directed test sequence.
   initial begin
      int t;
      int t2;
      int vBefore;
      compared        = 0;
      mismatched      = 0;
      validCount      = 0;
      divLat          = 5;
      forceQuot       = 1'b0;
      forceValue      = 16'd0;
      bus.en          = 1'b0;
      bus.sample_tick = 1'b0;
      clearNotes();
      nRst = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      checkOutput("rst_mixed_sample", 32'(bus.mixed_sample), 32'd0);
      checkOutput("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_div_start", 32'(bus.div_start), 32'd0);
      checkOutput("rst_div_dividend", 32'(bus.div_dividend), 32'd0);
      checkOutput("rst_div_divisor", 32'(bus.div_divisor), 32'd0);
      checkOutput("rst_note_sel", 32'(bus.note_sel), 32'd0);
      checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
      nRst = 1'b1;
      repeat (2) @(negedge clk);

      // All voices silent: no division, zero output at T+15.
      applyStimulus(1'b1, t);
      pushMix(12'h000, t + 15);
      checkOutput("busy_in_scan", 32'(bus.busy), 32'd1);
      waitUntil(t + 25);

      // Single active voice: divider bypassed.
      clearNotes();
      notes[4] = 12'h800;
      applyStimulus(1'b1, t);
      pushMix(12'h800, t + 15);
      waitUntil(t + 25);

      // Three full-scale voices: 0x2FFD / 3 = 0xFFF.
      clearNotes();
      notes[0] = 12'hFFF;
      notes[1] = 12'hFFF;
      notes[2] = 12'hFFF;
      divLat   = 5;
      applyStimulus(1'b1, t);
      pushDiv(16'h2FFD, 4'd3, t + 14);
      pushMix(12'hFFF, t + 21);
      waitUntil(t + 30);

      // Forced oversized quotient saturates.
      clearNotes();
      notes[2]   = 12'h100;
      notes[9]   = 12'h300;
      divLat     = 3;
      forceQuot  = 1'b1;
      forceValue = 16'h1234;
      applyStimulus(1'b1, t);
      pushDiv(16'h0400, 4'd2, t + 14);
      pushMix(12'hFFF, t + 19);
      waitUntil(t + 30);
      forceQuot = 1'b0;

      // Five active voices with gaps: 0xF0 / 5 = 0x30.
      clearNotes();
      notes[1]  = 12'h010;
      notes[3]  = 12'h020;
      notes[5]  = 12'h030;
      notes[8]  = 12'h040;
      notes[11] = 12'h050;
      divLat    = 2;
      applyStimulus(1'b1, t);
      pushDiv(16'h00F0, 4'd5, t + 14);
      pushMix(12'h030, t + 18);
      waitUntil(t + 30);

      // Tick while busy -> overrun, no extra scan; en=0 tick is ignored.
      clearNotes();
      notes[7] = 12'h123;
      applyStimulus(1'b1, t);
      pushMix(12'h123, t + 15);
      waitUntil(t + 5);
      applyStimulus(1'b1, t2);
      ovrQ.push_back(t2 + 1);
      waitUntil(t + 20);
      applyStimulus(1'b0, t2);
      checkOutput("busy_after_en0_tick", 32'(bus.busy), 32'd0);
      @(negedge clk);
      checkOutput("busy_after_en0_tick_2", 32'(bus.busy), 32'd0);
      waitUntil(t + 45);

      // Reset while waiting on the divider; its late div_done is ignored.
      clearNotes();
      notes[0] = 12'h100;
      notes[1] = 12'h100;
      divLat   = 20;
      applyStimulus(1'b1, t);
      pushDiv(16'h0200, 4'd2, t + 14);
      waitUntil(t + 18);
      #2 nRst = 1'b0;
      #1;
      checkOutput("midrst_mixed_sample", 32'(bus.mixed_sample), 32'd0);
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_div_dividend", 32'(bus.div_dividend), 32'd0);
      checkOutput("midrst_div_divisor", 32'(bus.div_divisor), 32'd0);
      checkOutput("midrst_sample_valid", 32'(bus.sample_valid), 32'd0);
      @(negedge clk);
      nRst    = 1'b1;
      vBefore = validCount;
      waitUntil(t + 45);
      checkOutput("no_valid_after_reset", validCount, vBefore);
      checkOutput("idle_after_reset", 32'(bus.busy), 32'd0);
      divLat = 5;

      // Only the last voice active: index NUM_NOTES-1 is included.
      clearNotes();
      notes[12] = 12'hABC;
      applyStimulus(1'b1, t);
      pushMix(12'hABC, t + 15);
      waitUntil(t + 25);

      // Every expected event must have been seen.
      checkOutput("pending_mix", mixQ.size(), 32'd0);
      checkOutput("pending_div", divQ.size(), 32'd0);
      checkOutput("pending_overrun", ovrQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
